// File: rtl/wave_ram_scan_arbiter_pkg.sv
// lcd_arb_pkg: shared types and constants for the waveform RAM scan arbiter.
//   arb_state_e : capture-lock FSM states
//   RD_LAT      : display read latency, disp_rd_en to disp_rd_valid, in cycles
//   STALL_W     : width of the writer stall statistic counter
package lcd_arb_pkg;

  typedef enum logic [1:0] {
    ST_OPEN     = 2'd0,
    ST_WAIT_ACT = 2'd1,
    ST_WAIT_END = 2'd2
  } arb_state_e;

  localparam int unsigned RD_LAT  = 3;
  localparam int unsigned STALL_W = 16;

endpackage

// File: rtl/wave_ram_scan_arbiter_edge_det.sv
// lcd_edge_det: registers a level signal and reports its edges.
// Ports:
//   clk    : clock
//   rst    : synchronous active-high reset (clears the registered copy)
//   sig_in : level input (v_de)
//   rise   : sig_in high now, low last cycle
//   fall   : sig_in low now, high last cycle
module lcd_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic sig_in,
  output logic rise,
  output logic fall
);

  logic sig_q;
  logic sig_d;

  always_comb begin
    sig_d = sig_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sig_q <= 1'b0;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign rise = sig_in && !sig_q;
  assign fall = !sig_in && sig_q;

endmodule

// File: rtl/wave_ram_scan_arbiter.sv
// wave_ram_scan_arbiter: shares a single-port waveform RAM between the LCD
// scan-out reader (absolute priority, never stalls) and the capture writer.
// A lock FSM keeps each finished capture on screen for one complete active
// frame before the writer may overwrite it.
// Optional feature: define WAVE_ARB_STATS_EN to build the saturating writer
// stall counter; otherwise wr_stall_cnt is constant zero.
// Parameters: AW address width, DW data width,
//   WR_WINDOW 0 = write on any display-idle cycle, 1 = only while v_de=0.
// Ports:
//   lcd_clk, sys_rst              : clock, synchronous active-high reset
//   v_de                          : vertical data enable
//   disp_rd_en/disp_addr          : display read request
//   disp_rd_valid/disp_rd_data    : display read return (3-cycle latency)
//   wr_valid/wr_ready/wr_addr/wr_data/wr_last : writer handshake
//   ram_en/ram_we/ram_addr/ram_wdata/ram_rdata : registered RAM port
//   capture_locked                : high while the lock FSM is not open
//   wr_stall_cnt                  : writer stall statistic
module wave_ram_scan_arbiter
  import lcd_arb_pkg::*;
#(
  parameter int unsigned AW        = 10,
  parameter int unsigned DW        = 8,
  parameter int unsigned WR_WINDOW = 0
) (
  input  logic               lcd_clk,
  input  logic               sys_rst,
  input  logic               v_de,
  input  logic               disp_rd_en,
  input  logic [AW-1:0]      disp_addr,
  output logic               disp_rd_valid,
  output logic [DW-1:0]      disp_rd_data,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [AW-1:0]      wr_addr,
  input  logic [DW-1:0]      wr_data,
  input  logic               wr_last,
  output logic               ram_en,
  output logic               ram_we,
  output logic [AW-1:0]      ram_addr,
  output logic [DW-1:0]      ram_wdata,
  input  logic [DW-1:0]      ram_rdata,
  output logic               capture_locked,
  output logic [STALL_W-1:0] wr_stall_cnt
);

  localparam int unsigned PW = RD_LAT - 1;

  logic v_de_rise;
  logic v_de_fall;

  lcd_edge_det u_edge_det (
    .clk    (lcd_clk),
    .rst    (sys_rst),
    .sig_in (v_de),
    .rise   (v_de_rise),
    .fall   (v_de_fall)
  );

  arb_state_e    state_q, state_d;
  logic          locked_q, locked_d;
  logic          ram_en_q, ram_en_d;
  logic          ram_we_q, ram_we_d;
  logic [AW-1:0] ram_addr_q, ram_addr_d;
  logic [DW-1:0] ram_wdata_q, ram_wdata_d;
  // bit 0: read issued to RAM, bit PW-1: RAM data present this cycle
  logic [PW-1:0] rd_pipe_q, rd_pipe_d;
  logic          rd_valid_q, rd_valid_d;
  logic [DW-1:0] rd_data_q, rd_data_d;

  logic wr_window_ok;
  logic wr_grant;
  logic wr_acc;

  assign wr_window_ok = (WR_WINDOW == 0) || !v_de;

  always_comb begin
    wr_grant = !sys_rst && !disp_rd_en && (state_q == ST_OPEN) && wr_window_ok;
    wr_acc   = wr_valid && wr_grant;
  end

  always_comb begin
    ram_en_d    = disp_rd_en || wr_acc;
    ram_we_d    = wr_acc;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    if (disp_rd_en) begin
      ram_addr_d = disp_addr;
    end else if (wr_acc) begin
      ram_addr_d  = wr_addr;
      ram_wdata_d = wr_data;
    end

    rd_pipe_d  = {rd_pipe_q[PW-2:0], disp_rd_en};
    rd_valid_d = rd_pipe_q[PW-1];
    rd_data_d  = rd_pipe_q[PW-1] ? ram_rdata : rd_data_q;
  end

  // Edges seen on the wr_last acceptance cycle fall in ST_OPEN and are
  // therefore ignored; only a later full rise..fall frame unlocks.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_OPEN:     if (wr_acc && wr_last) state_d = ST_WAIT_ACT;
      ST_WAIT_ACT: if (v_de_rise)         state_d = ST_WAIT_END;
      ST_WAIT_END: if (v_de_fall)         state_d = ST_OPEN;
      default:                            state_d = ST_OPEN;
    endcase
    locked_d = (state_d != ST_OPEN);
  end

  always_ff @(posedge lcd_clk) begin
    if (sys_rst) begin
      state_q     <= ST_OPEN;
      locked_q    <= 1'b0;
      ram_en_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      rd_pipe_q   <= '0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      locked_q    <= locked_d;
      ram_en_q    <= ram_en_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      rd_pipe_q   <= rd_pipe_d;
      rd_valid_q  <= rd_valid_d;
      rd_data_q   <= rd_data_d;
    end
  end

  assign wr_ready       = wr_grant;
  assign ram_en         = ram_en_q;
  assign ram_we         = ram_we_q;
  assign ram_addr       = ram_addr_q;
  assign ram_wdata      = ram_wdata_q;
  assign disp_rd_valid  = rd_valid_q;
  assign disp_rd_data   = rd_data_q;
  assign capture_locked = locked_q;

`ifdef WAVE_ARB_STATS_EN
  logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (wr_valid && !wr_grant && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + STALL_W'(1);
    end
  end

  always_ff @(posedge lcd_clk) begin
    if (sys_rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign wr_stall_cnt = stall_cnt_q;
`else
  assign wr_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_wave_ram_scan_arbiter.sv
// Directed self-checking bench for wave_ram_scan_arbiter.
// u_dut uses WR_WINDOW=0 with a behavioural RAM; u_dut_w1 uses WR_WINDOW=1
// and never sees wr_last, so it stays open for the write-window vectors.
module tb_wave_ram_scan_arbiter;

  localparam int unsigned AW = 10;
  localparam int unsigned DW = 8;

`ifdef WAVE_ARB_STATS_EN
  localparam bit STATS_ON = 1'b1;
`else
  localparam bit STATS_ON = 1'b0;
`endif

  logic          lcd_clk = 1'b0;
  logic          sys_rst;
  logic          v_de;
  logic          disp_rd_en;
  logic [AW-1:0] disp_addr;
  logic          wr_valid;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_last;

  logic          disp_rd_valid;
  logic [DW-1:0] disp_rd_data;
  logic          wr_ready;
  logic          ram_en;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;
  logic          capture_locked;
  logic [15:0]   wr_stall_cnt;

  logic          w1_rd_valid;
  logic [DW-1:0] w1_rd_data;
  logic          w1_wr_ready;
  logic          w1_ram_en;
  logic          w1_ram_we;
  logic [AW-1:0] w1_ram_addr;
  logic [DW-1:0] w1_ram_wdata;
  logic [DW-1:0] w1_ram_rdata;
  logic          w1_wr_last;
  logic          w1_locked;
  logic [15:0]   w1_stall_cnt;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  int n_checks = 0;
  int n_errors = 0;

  always #5 lcd_clk = ~lcd_clk;

  wave_ram_scan_arbiter #(.AW(AW), .DW(DW), .WR_WINDOW(0)) u_dut (
    .lcd_clk        (lcd_clk),
    .sys_rst        (sys_rst),
    .v_de           (v_de),
    .disp_rd_en     (disp_rd_en),
    .disp_addr      (disp_addr),
    .disp_rd_valid  (disp_rd_valid),
    .disp_rd_data   (disp_rd_data),
    .wr_valid       (wr_valid),
    .wr_ready       (wr_ready),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .wr_last        (wr_last),
    .ram_en         (ram_en),
    .ram_we         (ram_we),
    .ram_addr       (ram_addr),
    .ram_wdata      (ram_wdata),
    .ram_rdata      (ram_rdata),
    .capture_locked (capture_locked),
    .wr_stall_cnt   (wr_stall_cnt)
  );

  wave_ram_scan_arbiter #(.AW(AW), .DW(DW), .WR_WINDOW(1)) u_dut_w1 (
    .lcd_clk        (lcd_clk),
    .sys_rst        (sys_rst),
    .v_de           (v_de),
    .disp_rd_en     (disp_rd_en),
    .disp_addr      (disp_addr),
    .disp_rd_valid  (w1_rd_valid),
    .disp_rd_data   (w1_rd_data),
    .wr_valid       (wr_valid),
    .wr_ready       (w1_wr_ready),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .wr_last        (w1_wr_last),
    .ram_en         (w1_ram_en),
    .ram_we         (w1_ram_we),
    .ram_addr       (w1_ram_addr),
    .ram_wdata      (w1_ram_wdata),
    .ram_rdata      (w1_ram_rdata),
    .capture_locked (w1_locked),
    .wr_stall_cnt   (w1_stall_cnt)
  );

  // Single-port RAM with one cycle of read latency.
  always @(posedge lcd_clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata     <= mem[ram_addr];
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge lcd_clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    mem[5]       = 8'hA5;
    mem[6]       = 8'h5A;
    mem[7]       = 8'hC3;
    ram_rdata    = '0;
    w1_ram_rdata = '0;
    w1_wr_last   = 1'b0;

    // Reset with both requesters active.
    sys_rst    = 1'b1;
    v_de       = 1'b0;
    disp_rd_en = 1'b1;
    disp_addr  = '0;
    wr_valid   = 1'b1;
    wr_addr    = '0;
    wr_data    = '0;
    wr_last    = 1'b0;
    for (int i = 0; i < 2; i++) begin
      settle();
      check_eq("rst_wr_ready", wr_ready, 0);
      tick();
      check_eq("rst_ram_en", ram_en, 0);
      check_eq("rst_rd_valid", disp_rd_valid, 0);
      check_eq("rst_locked", capture_locked, 0);
    end
    sys_rst = 1'b0;
    settle();
    check_eq("post_rst_wr_ready", wr_ready, 0);
    check_eq("post_rst_ram_en", ram_en, 0);
    check_eq("post_rst_rd_valid", disp_rd_valid, 0);
    check_eq("post_rst_locked", capture_locked, 0);
    disp_rd_en = 1'b0;
    wr_valid   = 1'b0;
    tick();
    disp_rd_en = 1'b0;
    repeat (5) tick();

    // Single read, latency 3.
    disp_rd_en = 1'b1;
    disp_addr  = 10'h005;
    tick();
    check_eq("rd_n1_ram_en", ram_en, 1);
    check_eq("rd_n1_ram_we", ram_we, 0);
    check_eq("rd_n1_ram_addr", ram_addr, 10'h005);
    check_eq("rd_n1_valid", disp_rd_valid, 0);
    disp_rd_en = 1'b0;
    tick();
    check_eq("rd_n2_valid", disp_rd_valid, 0);
    tick();
    check_eq("rd_n3_valid", disp_rd_valid, 1);
    check_eq("rd_n3_data", disp_rd_data, 8'hA5);
    tick();
    check_eq("rd_n4_valid", disp_rd_valid, 0);

    // Back-to-back reads give back-to-back valids.
    disp_rd_en = 1'b1;
    disp_addr  = 10'h005;
    tick();
    disp_addr = 10'h006;
    tick();
    disp_addr = 10'h007;
    tick();
    disp_rd_en = 1'b0;
    check_eq("b2b_v0", disp_rd_valid, 1);
    check_eq("b2b_d0", disp_rd_data, 8'hA5);
    tick();
    check_eq("b2b_v1", disp_rd_valid, 1);
    check_eq("b2b_d1", disp_rd_data, 8'h5A);
    tick();
    check_eq("b2b_v2", disp_rd_valid, 1);
    check_eq("b2b_d2", disp_rd_data, 8'hC3);
    tick();
    check_eq("b2b_v3", disp_rd_valid, 0);
    repeat (3) tick();

    // Collision: writer waits out 4 display reads.
    wr_valid   = 1'b1;
    wr_addr    = 10'h010;
    wr_data    = 8'h3C;
    disp_rd_en = 1'b1;
    disp_addr  = 10'h005;
    for (int i = 0; i < 4; i++) begin
      settle();
      check_eq("coll_wr_ready", wr_ready, 0);
      tick();
      check_eq("coll_ram_we", ram_we, 0);
    end
    disp_rd_en = 1'b0;
    settle();
    check_eq("coll_grant", wr_ready, 1);
    tick();
    wr_valid = 1'b0;
    check_eq("coll_w_en", ram_en, 1);
    check_eq("coll_w_we", ram_we, 1);
    check_eq("coll_w_addr", ram_addr, 10'h010);
    check_eq("coll_w_data", ram_wdata, 8'h3C);
    tick();
    check_eq("coll_we_single", ram_we, 0);
    repeat (4) tick();

    // Written sample reads back.
    disp_rd_en = 1'b1;
    disp_addr  = 10'h010;
    tick();
    disp_rd_en = 1'b0;
    tick();
    tick();
    check_eq("wr_rb_valid", disp_rd_valid, 1);
    check_eq("wr_rb_data", disp_rd_data, 8'h3C);
    tick();

    // Write window: WR_WINDOW=1 only during blanking.
    wr_valid = 1'b1;
    wr_addr  = 10'h030;
    wr_data  = 8'h11;
    v_de     = 1'b1;
    settle();
    check_eq("win0_ready_active", wr_ready, 1);
    for (int i = 0; i < 100; i++) begin
      settle();
      check_eq("win1_ready_active", w1_wr_ready, 0);
      tick();
    end
    v_de = 1'b0;
    settle();
    check_eq("win1_ready_blank", w1_wr_ready, 1);
    check_eq("win0_ready_blank", wr_ready, 1);
    wr_valid = 1'b0;
    repeat (3) tick();

    // Lock: wr_last accepted in blanking.
    wr_valid = 1'b1;
    wr_last  = 1'b1;
    wr_addr  = 10'h020;
    wr_data  = 8'h55;
    settle();
    check_eq("lock_accept", wr_ready, 1);
    tick();
    wr_last = 1'b0;
    check_eq("lock_set", capture_locked, 1);
    for (int i = 0; i < 3; i++) begin
      settle();
      check_eq("lock_blank_ready", wr_ready, 0);
      tick();
    end
    v_de = 1'b1;
    for (int i = 0; i < 10; i++) begin
      settle();
      check_eq("lock_act_ready", wr_ready, 0);
      tick();
      check_eq("lock_act_locked", capture_locked, 1);
    end
    v_de = 1'b0;
    settle();
    check_eq("lock_fall_ready", wr_ready, 0);
    tick();
    check_eq("unlock", capture_locked, 0);
    settle();
    check_eq("unlock_ready", wr_ready, 1);
    wr_valid = 1'b0;
    repeat (3) tick();

    // wr_last accepted on the v_de rising cycle: that frame does not count.
    v_de     = 1'b1;
    wr_valid = 1'b1;
    wr_last  = 1'b1;
    settle();
    check_eq("coinc_accept", wr_ready, 1);
    tick();
    wr_valid = 1'b0;
    wr_last  = 1'b0;
    check_eq("coinc_locked", capture_locked, 1);
    repeat (4) tick();
    v_de = 1'b0;
    tick();
    tick();
    check_eq("coinc_hold", capture_locked, 1);
    v_de = 1'b1;
    repeat (5) tick();
    check_eq("coinc_frame2", capture_locked, 1);
    v_de = 1'b0;
    tick();
    check_eq("coinc_unlock", capture_locked, 0);
    repeat (2) tick();

    // Reset mid-read aborts the pending valid.
    disp_rd_en = 1'b1;
    disp_addr  = 10'h005;
    tick();
    sys_rst  = 1'b1;
    wr_valid = 1'b1;
    tick();
    check_eq("abort_v2", disp_rd_valid, 0);
    tick();
    check_eq("abort_v3", disp_rd_valid, 0);
    check_eq("stall_rst", wr_stall_cnt, 0);

    // Stall statistic: 70000 stalled cycles.
    sys_rst = 1'b0;
    repeat (10) tick();
    check_eq("stall_10", wr_stall_cnt, STATS_ON ? 32'd10 : 32'd0);
    repeat (69990) tick();
    check_eq("stall_sat", wr_stall_cnt, STATS_ON ? 32'hFFFF : 32'd0);
    disp_rd_en = 1'b0;
    wr_valid   = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
